// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl
//   Built-in self-test sequencer for a single-port RAM with a combinational
//   read port. On start it writes expected(k) = 2*k + seed (mod 2^WORD_SIZE)
//   to every address, reads every address back, counts the mismatches and
//   remembers the first failing address.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   start          begin a run (sampled only while idle)
//   mode           00 fill+verify, 01 fill only, 10 verify only, 11 = 00
//   seed           pattern offset, latched when the run starts
//   mem_addr       RAM address
//   mem_wdata      RAM write data
//   mem_wr         RAM write strobe (high only in the write-setup cycle)
//   mem_cs         RAM chip select
//   mem_rdata      RAM combinational read data
//   busy           run in progress
//   done           one-cycle pulse at the end of a run
//   pass           last run saw no mismatch (held until the next start)
//   err_count      mismatches seen in the last run
//   first_err_addr address of the first mismatch (valid when err_count != 0)
module ram_bist_ctrl #(
    parameter int ADDR_SIZE   = 10,
    parameter int WORD_SIZE   = 8,
    parameter int MEMORY_SIZE = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [WORD_SIZE-1:0] seed,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 mem_wr,
    output logic                 mem_cs,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_SIZE:0]   err_count,
    output logic [ADDR_SIZE-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        IDLE,
        WR_SET,
        WR_HOLD,
        RD_SET,
        RD_CMP,
        DONE
    } state_t;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEMORY_SIZE - 1);

    state_t                 state, state_nxt;
    logic [ADDR_SIZE-1:0]   k_q, k_nxt;
    logic [WORD_SIZE-1:0]   seed_q;
    logic [WORD_SIZE-1:0]   seed_eff;
    logic                   fill_only_q;

    logic [ADDR_SIZE-1:0]   mem_addr_nxt;
    logic [WORD_SIZE-1:0]   mem_wdata_nxt;
    logic                   mem_wr_nxt;
    logic                   mem_cs_nxt;
    logic                   busy_nxt;
    logic                   done_nxt;
    logic                   pass_nxt;
    logic [ADDR_SIZE:0]     err_nxt;
    logic [ADDR_SIZE-1:0]   first_nxt;

    // Test pattern: low WORD_SIZE bits of 2*addr + seed.
    function automatic logic [WORD_SIZE-1:0] pattern(
        input logic [ADDR_SIZE-1:0] a,
        input logic [WORD_SIZE-1:0] s
    );
        return WORD_SIZE'({a, 1'b0}) + s;
    endfunction

    always_comb begin
        state_nxt = state;
        k_nxt     = k_q;
        err_nxt   = err_count;
        first_nxt = first_err_addr;
        pass_nxt  = pass;
        // The live seed drives the very first write, since seed_q is only
        // loaded on the same edge that leaves IDLE.
        seed_eff  = (state == IDLE) ? seed : seed_q;

        unique case (state)
            IDLE: begin
                if (start) begin
                    err_nxt   = '0;
                    first_nxt = '0;
                    pass_nxt  = 1'b0;
                    k_nxt     = '0;
                    state_nxt = (mode == 2'b10) ? RD_SET : WR_SET;
                end
            end
            WR_SET: state_nxt = WR_HOLD;
            WR_HOLD: begin
                if (k_q == LAST_ADDR) begin
                    k_nxt     = '0;
                    state_nxt = fill_only_q ? DONE : RD_SET;
                end else begin
                    k_nxt     = k_q + ADDR_SIZE'(1);
                    state_nxt = WR_SET;
                end
            end
            RD_SET: state_nxt = RD_CMP;
            RD_CMP: begin
                if (mem_rdata != pattern(k_q, seed_q)) begin
                    err_nxt = err_count + (ADDR_SIZE+1)'(1);
                    if (err_count == '0) begin
                        first_nxt = k_q;
                    end
                end
                if (k_q == LAST_ADDR) begin
                    k_nxt     = '0;
                    state_nxt = DONE;
                end else begin
                    k_nxt     = k_q + ADDR_SIZE'(1);
                    state_nxt = RD_SET;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being
        // entered; pass includes a mismatch found in the final compare.
        if (state_nxt == DONE) begin
            pass_nxt = (err_nxt == '0);
        end
        busy_nxt      = (state_nxt == WR_SET) || (state_nxt == WR_HOLD) ||
                        (state_nxt == RD_SET) || (state_nxt == RD_CMP);
        done_nxt      = (state_nxt == DONE);
        mem_cs_nxt    = busy_nxt;
        mem_wr_nxt    = (state_nxt == WR_SET);
        mem_addr_nxt  = busy_nxt ? k_nxt : '0;
        mem_wdata_nxt = ((state_nxt == WR_SET) || (state_nxt == WR_HOLD)) ?
                        pattern(k_nxt, seed_eff) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            k_q            <= '0;
            fill_only_q    <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wr         <= 1'b0;
            mem_cs         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            state          <= state_nxt;
            k_q            <= k_nxt;
            if (state == IDLE && start) begin
                fill_only_q <= (mode == 2'b01);
            end
            mem_addr       <= mem_addr_nxt;
            mem_wdata      <= mem_wdata_nxt;
            mem_wr         <= mem_wr_nxt;
            mem_cs         <= mem_cs_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            err_count      <= err_nxt;
            first_err_addr <= first_nxt;
        end
    end

    // Pattern seed is plain data and needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            seed_q <= seed;
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
module tb_ram_bist_ctrl;

    localparam int AW  = 10;
    localparam int WW  = 8;
    localparam int MS  = 1024;
    localparam int MSS = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode  = 2'b00;
    logic [WW-1:0] seed  = '0;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          mem_wr;
    logic          mem_cs;
    logic [WW-1:0] mem_rdata;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_addr;

    logic          start_s = 1'b0;
    logic [WW-1:0] seed_s  = '0;
    logic [AW-1:0] mem_addr_s;
    logic [WW-1:0] mem_wdata_s;
    logic          mem_wr_s;
    logic          mem_cs_s;
    logic [WW-1:0] mem_rdata_s;
    logic          busy_s;
    logic          done_s;
    logic          pass_s;
    logic [AW:0]   err_count_s;
    logic [AW-1:0] first_err_addr_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .MEMORY_SIZE(MS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_cs(mem_cs), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
    );

    ram_bist_ctrl #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .MEMORY_SIZE(MSS)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .mode(2'b00), .seed(seed_s),
        .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .mem_wr(mem_wr_s),
        .mem_cs(mem_cs_s), .mem_rdata(mem_rdata_s), .busy(busy_s), .done(done_s),
        .pass(pass_s), .err_count(err_count_s), .first_err_addr(first_err_addr_s)
    );

    // RAM models: synchronous write, combinational read, optional stuck-at-1 bits
    logic [WW-1:0] ram  [MS];
    logic [WW-1:0] s1   [MS];
    logic [WW-1:0] rams [MSS];

    always @(posedge clk) if (mem_cs && mem_wr) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = ram[mem_addr] | s1[mem_addr];

    always @(posedge clk) if (mem_cs_s && mem_wr_s) rams[mem_addr_s[3:0]] <= mem_wdata_s;
    assign mem_rdata_s = rams[mem_addr_s[3:0]];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int pat(input int k, input int s);
        return (2 * k + s) % 256;
    endfunction

    // Behavioural model: on an accepted start, the whole run is expanded into
    // a queue of per-cycle expected outputs derived from the pattern rule and
    // a shadow image of the RAM contents.
    typedef struct {
        bit busy; bit done; bit pass; bit cs; bit wr;
        bit acare; bit wcare;
        int addr; int wdata; int err; int first;
    } exp_t;

    exp_t          q[$];
    exp_t          cur;
    logic [WW-1:0] shadow [MS];
    logic [WW-1:0] img    [MS];
    bit            model_on = 0;
    int            w200 = -1;

    task automatic build(input int m, input int s);
        exp_t e;
        bit   fill;
        bit   ver;
        int   err;
        int   first;
        int   rd;
        fill  = (m != 2);
        ver   = (m != 1);
        err   = 0;
        first = 0;
        for (int i = 0; i < MS; i++) img[i] = shadow[i];
        if (fill) begin
            for (int k = 0; k < MS; k++) begin
                e = '{default: 0};
                e.busy = 1; e.cs = 1; e.acare = 1; e.wcare = 1;
                e.addr = k; e.wdata = pat(k, s);
                e.wr = 1; q.push_back(e);
                e.wr = 0; q.push_back(e);
                img[k] = 8'(pat(k, s));
            end
        end
        if (ver) begin
            for (int k = 0; k < MS; k++) begin
                e = '{default: 0};
                e.busy = 1; e.cs = 1; e.acare = 1;
                e.addr = k; e.err = err; e.first = first;
                q.push_back(e);
                q.push_back(e);
                rd = int'(img[k] | s1[k]);
                if (rd != pat(k, s)) begin
                    if (err == 0) first = k;
                    err++;
                end
            end
        end
        e = '{default: 0};
        e.done = 1; e.pass = (err == 0); e.err = err; e.first = first;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            cur = '{default: 0};
            cur.acare = 1;
            cur.wcare = 1;
        end else if (q.size() != 0) begin
            cur = q.pop_front();
        end else if (!cur.busy && !cur.done && start) begin
            build(int'(mode), int'(seed));
            cur = q.pop_front();
        end else begin
            cur.busy = 0; cur.done = 0; cur.cs = 0; cur.wr = 0;
            cur.acare = 0; cur.wcare = 0;
        end
        if (cur.wr) shadow[cur.addr] = 8'(cur.wdata);
        model_on = 1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("busy", int'(busy), int'(cur.busy));
            chk("done", int'(done), int'(cur.done));
            chk("pass", int'(pass), int'(cur.pass));
            chk("mem_cs", int'(mem_cs), int'(cur.cs));
            chk("mem_wr", int'(mem_wr), int'(cur.wr));
            chk("err_count", int'(err_count), cur.err);
            chk("first_err_addr", int'(first_err_addr), cur.first);
            if (cur.acare) chk("mem_addr", int'(mem_addr), cur.addr);
            if (cur.wcare) chk("mem_wdata", int'(mem_wdata), cur.wdata);
            if (mem_wr && mem_addr == 10'd200) w200 = int'(mem_wdata);
        end
    end

    // Issue a run from an idle cycle; returns cycles from the accepting edge
    // to the observed done pulse (-1 if it never arrives).
    task automatic run(input int m, input int s, input int stray, output int lat);
        w200  = -1;
        mode  = 2'(m);
        seed  = 8'(s);
        start = 1'b1;
        lat   = -1;
        for (int n = 1; n <= 5000; n++) begin
            @(negedge clk);
            start = (n == stray);
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_faults();
        for (int i = 0; i < MS; i++) s1[i] = '0;
    endtask

    initial begin
        int lat;
        int m;
        int s;
        int mx;
        for (int i = 0; i < MS; i++) begin
            ram[i] = '0; s1[i] = '0; shadow[i] = '0;
        end
        for (int i = 0; i < MSS; i++) rams[i] = '0;

        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset mem_cs", int'(mem_cs), 0);
        chk("reset mem_wr", int'(mem_wr), 0);
        chk("reset err_count", int'(err_count), 0);
        chk("reset pass", int'(pass), 0);
        chk("reset mem_addr", int'(mem_addr), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // fill+verify, seed 0, clean RAM
        run(0, 0, -1, lat);
        chk("m00 done latency", lat, 4097);
        chk("m00 pass", int'(pass), 1);
        chk("m00 err_count", int'(err_count), 0);
        chk("m00 wdata@200", w200, 144);

        // stuck-at-1 bit 0 at addresses 5 and 900
        s1[5] = 8'h01; s1[900] = 8'h01;
        run(0, 8'h10, -1, lat);
        chk("fault latency", lat, 4097);
        chk("fault err_count", int'(err_count), 2);
        chk("fault first_err_addr", int'(first_err_addr), 5);
        chk("fault pass", int'(pass), 0);
        chk("fault wdata@200", w200, 160);
        clear_faults();

        // fill only, then verify only with matching and mismatching seeds
        run(1, 8'h03, -1, lat);
        chk("fill-only latency", lat, 2049);
        run(2, 8'h03, -1, lat);
        chk("verify latency", lat, 2049);
        chk("verify pass", int'(pass), 1);
        run(2, 8'h04, -1, lat);
        chk("bad verify err_count", int'(err_count), 1024);
        chk("bad verify first_err_addr", int'(first_err_addr), 0);
        chk("bad verify pass", int'(pass), 0);

        // mode 11 behaves as 00; stray start mid-run is ignored
        run(3, int'($urandom_range(255, 0)), 50, lat);
        chk("m11 stray-start latency", lat, 4097);
        chk("m11 pass", int'(pass), 1);

        // reset during a write-setup cycle
        mode  = 2'b00;
        seed  = 8'($urandom_range(255, 0));
        start = 1'b1;
        for (int n = 1; n <= 101; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 101) begin
                chk("pre-reset mem_wr", int'(mem_wr), 1);
                rst_n = 1'b0;
            end
        end
        @(negedge clk);
        chk("abort mem_wr", int'(mem_wr), 0);
        chk("abort mem_cs", int'(mem_cs), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort err_count", int'(err_count), 0);
        chk("abort first_err_addr", int'(first_err_addr), 0);
        chk("abort pass", int'(pass), 0);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("no done after abort", int'(done), 0);
        end
        run(0, int'($urandom_range(255, 0)), -1, lat);
        chk("post-reset latency", lat, 4097);
        chk("post-reset pass", int'(pass), 1);

        // randomized runs with random stuck-at-1 bits
        for (int r = 0; r < 4; r++) begin
            m = int'($urandom_range(3, 0));
            s = int'($urandom_range(255, 0));
            for (int f = 0; f < 3; f++)
                s1[$urandom_range(MS - 1, 0)] = 8'(1 << $urandom_range(7, 0));
            run(m, s, -1, lat);
            chk("random latency", lat, (m == 1 || m == 2) ? 2049 : 4097);
            clear_faults();
        end

        // 16-word instance: address wraps 15 -> 0 between phases
        seed_s  = 8'($urandom_range(255, 0));
        start_s = 1'b1;
        lat = -1;
        mx  = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (mem_cs_s) begin
                if (int'(mem_addr_s) > mx) mx = int'(mem_addr_s);
                chk("small mem_addr", int'(mem_addr_s), ((n - 1) / 2) % MSS);
            end
            if (done_s) begin
                lat = n;
                break;
            end
        end
        chk("small done latency", lat, 65);
        chk("small max addr", mx, 15);
        chk("small pass", int'(pass_s), 1);
        chk("small err_count", int'(err_count_s), 0);
        chk("small first_err_addr", int'(first_err_addr_s), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
